// File: rtl/seq_resp_checker_pkg.sv
// Shared types and helpers for the sequence response checker and its expected-value ROM.
// Holds the run-state encoding and the packed-parameter slicing function.
package seq_chk_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    CHK_IDLE = ST_IDLE,
    CHK_RUN  = ST_RUN,
    CHK_DONE = ST_DONE
  } chk_state_t;

  // Upper bounds for the generic slicer; N_STEPS*W must fit in SLICE_VEC_MAX.
  localparam int SLICE_VEC_MAX = 1024;
  localparam int SLICE_MAX_W   = 32;

  function automatic logic [SLICE_MAX_W-1:0] step_slice(
    input logic [SLICE_VEC_MAX-1:0] vec,
    input int                       k,
    input int                       w
  );
    logic [SLICE_VEC_MAX-1:0] v_sh;
    logic [SLICE_MAX_W-1:0]   v_out;
    v_sh  = vec >> (k * w);
    v_out = '0;
    for (int i = 0; i < SLICE_MAX_W; i++) begin
      if (i < w) v_out[i] = v_sh[i];
    end
    return v_out;
  endfunction

endpackage

// File: rtl/seq_resp_checker_exp_rom.sv
// Combinational lookup of the expected value and compare mask for one step.
// Zero latency; no flow control.
module exp_rom
  import seq_chk_pkg::*;
#(
  parameter int                   W       = 3,
  parameter int                   N_STEPS = 8,
  parameter logic [N_STEPS*W-1:0] EXP     = '0,
  parameter logic [N_STEPS*W-1:0] MASK    = '1,
  parameter int                   IW      = $clog2(N_STEPS)
) (
  input  logic [IW-1:0] i_idx,
  output logic [W-1:0]  o_exp,
  output logic [W-1:0]  o_mask
);

  logic [SLICE_VEC_MAX-1:0] w_exp_vec;
  logic [SLICE_VEC_MAX-1:0] w_mask_vec;
  logic [SLICE_MAX_W-1:0]   w_exp_full;
  logic [SLICE_MAX_W-1:0]   w_mask_full;
  logic                     w_unused;

  assign w_exp_vec  = SLICE_VEC_MAX'(EXP);
  assign w_mask_vec = SLICE_VEC_MAX'(MASK);

  assign w_exp_full  = step_slice(w_exp_vec,  int'(i_idx), W);
  assign w_mask_full = step_slice(w_mask_vec, int'(i_idx), W);

  assign o_exp  = w_exp_full[W-1:0];
  assign o_mask = w_mask_full[W-1:0];

  // Slicer returns a fixed-width word; bits above W are always zero.
  assign w_unused = ^{w_exp_full, w_mask_full};

endmodule

// File: rtl/seq_resp_checker.sv
// Strobed capture-and-compare of an observed vector against a parameter-held sequence.
// Results registered 1 cycle after each strobe; strobes may have arbitrary gaps, no backpressure.
module seq_resp_checker
  import seq_chk_pkg::*;
#(
  parameter int                   W       = 3,
  parameter int                   N_STEPS = 8,
  parameter logic [N_STEPS*W-1:0] EXP     = '0,
  parameter logic [N_STEPS*W-1:0] MASK    = '1,
  parameter int                   CW      = $clog2(N_STEPS + 1),
  parameter int                   IW      = $clog2(N_STEPS)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_start,
  input  logic          i_sample_en,
  input  logic [W-1:0]  i_obs,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_pass,
  output logic [CW-1:0] o_err_cnt,
  output logic [IW-1:0] o_first_err,
  output logic [IW-1:0] o_step_idx
);

  chk_state_t    r_state;
  logic          r_busy;
  logic          r_done;
  logic          r_pass;
  logic [CW-1:0] r_err_cnt;
  logic [IW-1:0] r_first_err;
  logic [IW-1:0] r_step_idx;

  logic [W-1:0]  w_exp;
  logic [W-1:0]  w_mask;
  logic [W-1:0]  w_diff;
  logic          w_mis;
  logic          w_last;

  exp_rom #(
    .W       (W),
    .N_STEPS (N_STEPS),
    .EXP     (EXP),
    .MASK    (MASK)
  ) u_exp_rom (
    .i_idx  (r_step_idx),
    .o_exp  (w_exp),
    .o_mask (w_mask)
  );

  assign w_diff = (i_obs ^ w_exp) & w_mask;
  assign w_last = (r_step_idx == IW'(N_STEPS - 1));

  // Default to mismatch so an unknown observed bit in simulation counts as an error.
  always_comb begin
    w_mis = 1'b1;
    if (w_diff == '0) w_mis = 1'b0;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= CHK_IDLE;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_err_cnt   <= '0;
      r_first_err <= '0;
      r_step_idx  <= '0;
    end else begin
      case (r_state)
        CHK_IDLE, CHK_DONE: begin
          if (i_start) begin
            r_state     <= CHK_RUN;
            r_busy      <= 1'b1;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_err_cnt   <= '0;
            r_first_err <= '0;
            r_step_idx  <= '0;
          end
        end
        CHK_RUN: begin
          if (i_sample_en) begin
            if (w_mis) begin
              r_err_cnt <= r_err_cnt + 1'b1;
              if (r_err_cnt == '0) r_first_err <= r_step_idx;
            end
            if (w_last) begin
              r_state <= CHK_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_pass  <= (r_err_cnt == '0) && !w_mis;
            end else begin
              r_step_idx <= r_step_idx + 1'b1;
            end
          end
        end
        default: begin
          r_state <= CHK_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_pass  <= 1'b0;
        end
      endcase
    end
  end

  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_pass      = r_pass;
  assign o_err_cnt   = r_err_cnt;
  assign o_first_err = r_first_err;
  assign o_step_idx  = r_step_idx;

endmodule

// File: tb/tb_seq_resp_checker.sv
// Directed bench for seq_resp_checker: expected run results are queued by the stimulus
// and popped by a monitor whenever done rises.
module tb_seq_resp_checker;

  localparam int W = 3;
  localparam int N = 8;
  // Steps 7..0 = 111,001,111,111,000,000,000,000
  localparam logic [N*W-1:0] P_EXP  = 24'b111_001_111_111_000_000_000_000;
  // Step 6 ignores bit 0, all other steps compare every bit.
  localparam logic [N*W-1:0] P_MASK = 24'b111_110_111_111_111_111_111_111;

  logic       i_clk;
  logic       i_rst_n;
  logic       i_start;
  logic       i_sample_en;
  logic [2:0] i_obs;
  logic       o_busy;
  logic       o_done;
  logic       o_pass;
  logic [3:0] o_err_cnt;
  logic [2:0] o_first_err;
  logic [2:0] o_step_idx;

  seq_resp_checker #(
    .W       (W),
    .N_STEPS (N),
    .EXP     (P_EXP),
    .MASK    (P_MASK)
  ) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_start     (i_start),
    .i_sample_en (i_sample_en),
    .i_obs       (i_obs),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_pass      (o_pass),
    .o_err_cnt   (o_err_cnt),
    .o_first_err (o_first_err),
    .o_step_idx  (o_step_idx)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  logic [2:0] exp_v [0:7] = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b111, 3'b111, 3'b001, 3'b111};

  typedef struct {
    int err;
    int first;
    int pass;
  } res_t;

  res_t exp_q [$];
  int   n_total = 0;
  int   n_pass  = 0;

  task automatic check(input string name, input int act, input int req);
    n_total++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, required %0d", name, act, req);
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic strobe(input logic [2:0] o);
    i_sample_en = 1'b1;
    i_obs       = o;
    step();
    i_sample_en = 1'b0;
    i_obs       = 3'b000;
  endtask

  task automatic start_run();
    i_start = 1'b1;
    step();
    i_start = 1'b0;
  endtask

  task automatic push_exp(input int e, input int f, input int p);
    res_t r;
    r.err   = e;
    r.first = f;
    r.pass  = p;
    exp_q.push_back(r);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},      int'(o_busy),      0);
    check({tag, "_done"},      int'(o_done),      0);
    check({tag, "_pass"},      int'(o_pass),      0);
    check({tag, "_err_cnt"},   int'(o_err_cnt),   0);
    check({tag, "_first_err"}, int'(o_first_err), 0);
    check({tag, "_step_idx"},  int'(o_step_idx),  0);
  endtask

  // Monitor: every rising edge of done must match the next queued run result.
  initial begin
    logic prev_done;
    res_t r;
    prev_done = 1'b0;
    forever begin
      @(negedge i_clk);
      if (o_done && !prev_done) begin
        if (exp_q.size() == 0) begin
          check("done_unexpected", 1, 0);
        end else begin
          r = exp_q.pop_front();
          check("run_err_cnt",   int'(o_err_cnt),   r.err);
          check("run_first_err", int'(o_first_err), r.first);
          check("run_pass",      int'(o_pass),      r.pass);
          check("run_busy",      int'(o_busy),      0);
          check("run_step_idx",  int'(o_step_idx),  N - 1);
        end
      end
      prev_done = o_done;
    end
  end

  initial begin
    i_rst_n     = 1'b0;
    i_start     = 1'b0;
    i_sample_en = 1'b0;
    i_obs       = 3'b000;
    step();
    check_all_zero("reset");
    i_rst_n = 1'b1;
    step();

    // Start and strobe together in IDLE: the strobe must not count.
    push_exp(0, 0, 1);
    i_start     = 1'b1;
    i_sample_en = 1'b1;
    i_obs       = 3'b111;
    step();
    i_start     = 1'b0;
    i_sample_en = 1'b0;
    i_obs       = 3'b000;
    check("start_busy",      int'(o_busy),     1);
    check("start_step_idx",  int'(o_step_idx), 0);
    check("start_err_cnt",   int'(o_err_cnt),  0);
    for (int k = 0; k < 4; k++) strobe(exp_v[k]);
    check("mid_step_idx", int'(o_step_idx), 4);
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    check("start_in_run_step_idx", int'(o_step_idx), 4);
    check("start_in_run_busy",     int'(o_busy),     1);
    for (int k = 4; k < 8; k++) strobe(exp_v[k]);
    // Strobe in DONE with wrong data must be ignored.
    strobe(3'b010);
    check("done_hold_err_cnt", int'(o_err_cnt), 0);
    check("done_hold_done",    int'(o_done),    1);
    check("done_hold_pass",    int'(o_pass),    1);

    // Clean back-to-back run started from DONE.
    push_exp(0, 0, 1);
    start_run();
    check("rerun_busy", int'(o_busy), 1);
    check("rerun_done", int'(o_done), 0);
    for (int k = 0; k < 8; k++) strobe(exp_v[k]);

    // Two errors at steps 2 and 5.
    push_exp(2, 2, 0);
    start_run();
    for (int k = 0; k < 8; k++) begin
      strobe(k == 2 ? 3'b010 : (k == 5 ? 3'b101 : exp_v[k]));
      if (k == 2) begin
        check("err2_err_cnt",   int'(o_err_cnt),   1);
        check("err2_first_err", int'(o_first_err), 2);
      end
    end

    // Masked bit differs at step 6, strobes every third cycle.
    push_exp(0, 0, 1);
    start_run();
    for (int k = 0; k < 8; k++) begin
      strobe(k == 6 ? 3'b000 : exp_v[k]);
      if (k == 6) check("mask_dontcare_err_cnt", int'(o_err_cnt), 0);
      if (k < 7) begin
        step();
        step();
      end
      if (k == 6) begin
        check("gap_done_low",  int'(o_done),     0);
        check("gap_step_idx",  int'(o_step_idx), 7);
      end
    end

    // Unmasked bit differs at step 6.
    push_exp(1, 6, 0);
    start_run();
    for (int k = 0; k < 8; k++) strobe(k == 6 ? 3'b011 : exp_v[k]);

    // Reset after three strobes with one error.
    start_run();
    strobe(exp_v[0]);
    strobe(3'b111);
    strobe(exp_v[2]);
    check("prerst_err_cnt",   int'(o_err_cnt),   1);
    check("prerst_first_err", int'(o_first_err), 1);
    check("prerst_step_idx",  int'(o_step_idx),  3);
    i_rst_n = 1'b0;
    #1;
    check_all_zero("midrst");
    step();
    i_rst_n = 1'b1;
    step();
    check("postrst_busy", int'(o_busy), 0);
    push_exp(0, 0, 1);
    start_run();
    for (int k = 0; k < 8; k++) strobe(exp_v[k]);

    // Three errors (steps 3, 4, 7), then rerun clears results.
    push_exp(3, 3, 0);
    start_run();
    for (int k = 0; k < 8; k++)
      strobe(k == 3 ? 3'b001 : (k == 4 ? 3'b011 : (k == 7 ? 3'b000 : exp_v[k])));
    step();
    start_run();
    check("clear_err_cnt",   int'(o_err_cnt),   0);
    check("clear_first_err", int'(o_first_err), 0);
    check("clear_done",      int'(o_done),      0);
    check("clear_pass",      int'(o_pass),      0);
    check("clear_busy",      int'(o_busy),      1);

    step();
    step();
    check("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
